// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int MAX_LEN = 8;

  typedef logic [$clog2(MAX_LEN+1)-1:0] len_t;
  typedef logic [MAX_LEN-1:0]           pat_t;

  // Bit i is set when history bit i takes part in the pattern compare.
  function automatic pat_t len_mask(input len_t len);
    pat_t m;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (len_t'(i) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// configuration validation and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   MAX_LEN         = seq_det_pkg::MAX_LEN,
  parameter int                   DEFAULT_LEN     = 4,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(8'b0000_1101),
  parameter int                   CNT_W           = 8,
  localparam int                  LEN_W           = $clog2(MAX_LEN+1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               match_q, match_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_sh;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_ok;
  logic               hit;

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign hist_sh  = {hist_q[MAX_LEN-2:0], in_bit};
  assign fill_inc = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
  // Only the low len bits of history take part; older bits are don't-care.
  assign hit      = (fill_inc == len_q) && (((hist_sh ^ pat_q) & mask) == '0);

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (in_valid) begin
      hist_d  = hist_sh;
      match_d = hit;
      // Non-overlapping mode restarts the fill so the next match needs len new bits.
      fill_d  = (hit && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEFAULT_PATTERN;
      len_q   <= LEN_W'(DEFAULT_LEN);
      ovl_q   <= 1'b1;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  // Counter advances on the same edge that raises match.
  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (match_d),
    .count (match_count)
  );

  assign match   = match_q;
  assign cfg_err = err_q;

endmodule
